pwm_vip_monitor: RTL and testbench

//  Self-checking PWM monitor for SoC-level simulation. Samples the PWM pad of the PWM

---
 rtl/pwm_vip_pkg.sv | 18 +
 rtl/pwm_edge_sync.sv | 32 +++
 rtl/pwm_vip_monitor.sv | 141 ++++++++++++++
 tb/tb_pwm_vip_monitor.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_vip_pkg.sv
// Shared types and verdict codes for the PWM monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_vip_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HIGH,
        LOW,
        PASS,
        FAIL
    } state_t;

    localparam logic [3:0] DB_RUN  = 4'h0;
    localparam logic [3:0] DB_PASS = 4'hA;
    localparam logic [3:0] DB_FAIL = 4'hF;

endpackage

// File: rtl/pwm_edge_sync.sv
// 2-FF synchronizer for an asynchronous pad plus registered rise/fall pulses.
// Latency: pulse is visible 3 cycles after the pad edge.
// Backpressure: none; one-cycle pulses, free running.
module pwm_edge_sync (
    input  logic core_clk,
    input  logic arst_n,
    input  logic din,
    output logic rise_vld,
    output logic fall_vld
);

    logic sync_q1;
    logic sync_q2;
    logic sync_q3;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q1  <= 1'b0;
            sync_q2  <= 1'b0;
            sync_q3  <= 1'b0;
            rise_vld <= 1'b0;
            fall_vld <= 1'b0;
        end else begin
            sync_q1  <= din;
            sync_q2  <= sync_q1;
            sync_q3  <= sync_q2;
            rise_vld <= sync_q2 & ~sync_q3;
            fall_vld <= ~sync_q2 & sync_q3;
        end
    end

endmodule

// File: rtl/pwm_vip_monitor.sv
// Measures PWM high time and period, checks against expected values, sticky verdict.
// Latency: measurement/verdict registered 4 cycles after the closing pad rise.
// Backpressure: none; observes the pad only.
module pwm_vip_monitor
    import pwm_vip_pkg::*;
#(
    parameter int CW          = 16,
    parameter int EXP_PERIOD  = 100,
    parameter int EXP_HIGH    = 50,
    parameter int TOL         = 2,
    parameter int NUM_PERIODS = 4,
    parameter int TIMEOUT     = 2048
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          pwm,
    output logic [3:0]    db_reg,
    output logic [CW-1:0] meas_high,
    output logic [CW-1:0] meas_per
);

    localparam int            MW       = $clog2(NUM_PERIODS + 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW:0]   EXP_H_W  = (CW+1)'(EXP_HIGH);
    localparam logic [CW:0]   EXP_P_W  = (CW+1)'(EXP_PERIOD);
    localparam logic [CW:0]   TOL_W    = (CW+1)'(TOL);
    localparam logic [MW-1:0] NUM_P_W  = MW'(NUM_PERIODS);

    state_t        state, state_nxt;
    logic          rise_vld, fall_vld;
    logic [CW-1:0] high_cnt, per_cnt, idle_cnt;
    logic [CW-1:0] high_nxt, per_nxt, idle_nxt, mh_nxt, mp_nxt;
    logic [MW-1:0] match_cnt, mcnt_nxt, mcnt_inc;
    logic [CW:0]   dev_high, dev_per;
    logic          period_ok;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [CW:0] abs_dev(input logic [CW-1:0] v, input logic [CW:0] ref_v);
        logic signed [CW:0] d;
        d = $signed({1'b0, v}) - $signed(ref_v);
        return (d < 0) ? $unsigned(-d) : $unsigned(d);
    endfunction

    pwm_edge_sync u_sync (
        .core_clk (HCLK),
        .arst_n   (HRESETn),
        .din      (pwm),
        .rise_vld (rise_vld),
        .fall_vld (fall_vld)
    );

    assign dev_high  = abs_dev(high_cnt, EXP_H_W);
    assign dev_per   = abs_dev(per_cnt, EXP_P_W);
    assign mcnt_inc  = match_cnt + 1'b1;
    // A saturated counter means the true value is unknown, so it never matches.
    assign period_ok = (dev_high <= TOL_W) && (dev_per <= TOL_W) &&
                       (high_cnt != CNT_MAX) && (per_cnt != CNT_MAX);

    always_comb begin
        state_nxt = state;
        high_nxt  = high_cnt;
        per_nxt   = per_cnt;
        idle_nxt  = idle_cnt;
        mcnt_nxt  = match_cnt;
        mh_nxt    = meas_high;
        mp_nxt    = meas_per;
        case (state)
            IDLE: begin
                if (rise_vld) begin
                    state_nxt = HIGH;
                    high_nxt  = CNT_ONE;
                    per_nxt   = CNT_ONE;
                    idle_nxt  = '0;
                end
            end
            HIGH: begin
                per_nxt = sat_inc(per_cnt);
                if (fall_vld) state_nxt = LOW;
                else          high_nxt  = sat_inc(high_cnt);
            end
            LOW: begin
                if (rise_vld) begin
                    mh_nxt    = high_cnt;
                    mp_nxt    = per_cnt;
                    high_nxt  = CNT_ONE;
                    per_nxt   = CNT_ONE;
                    state_nxt = HIGH;
                    if (!period_ok)                 mcnt_nxt = '0;
                    else begin
                        mcnt_nxt = mcnt_inc;
                        if (mcnt_inc == NUM_P_W) state_nxt = PASS;
                    end
                end else begin
                    per_nxt = sat_inc(per_cnt);
                end
            end
            default: ;
        endcase
        // Watchdog on a stuck pad once a run has started; IDLE waits forever.
        if (state == HIGH || state == LOW) begin
            if (rise_vld || fall_vld)     idle_nxt  = '0;
            else if (idle_cnt == TO_LAST) state_nxt = FAIL;
            else                          idle_nxt  = sat_inc(idle_cnt);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            high_cnt  <= '0;
            per_cnt   <= '0;
            idle_cnt  <= '0;
            match_cnt <= '0;
            meas_high <= '0;
            meas_per  <= '0;
            db_reg    <= DB_RUN;
        end else begin
            high_cnt  <= high_nxt;
            per_cnt   <= per_nxt;
            idle_cnt  <= idle_nxt;
            match_cnt <= mcnt_nxt;
            meas_high <= mh_nxt;
            meas_per  <= mp_nxt;
            db_reg    <= (state_nxt == PASS) ? DB_PASS :
                         (state_nxt == FAIL) ? DB_FAIL : DB_RUN;
        end
    end

endmodule

// File: tb/tb_pwm_vip_monitor.sv
// Directed + randomized bench for pwm_vip_monitor with a period-level reference model.
module tb_pwm_vip_monitor;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        pwm;
    logic [3:0]  db_reg;
    logic [15:0] meas_high;
    logic [15:0] meas_per;

    int checks = 0;
    int errors = 0;
    int test_id = 0;

    // Reference model state: verdict, last measured pair, current run of good periods.
    int exp_db, exp_h, exp_p, run_len;
    bit pending;
    int pend_h, pend_p;

    always #5 HCLK = ~HCLK;

    pwm_vip_monitor dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .pwm       (pwm),
        .db_reg    (db_reg),
        .meas_high (meas_high),
        .meas_per  (meas_per)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL t%0d %s: observed %0h expected %0h", test_id, tag, obs, exp);
        end
    endtask

    function automatic bit in_tol(input int v, input int target);
        return (v - target <= 2) && (target - v <= 2);
    endfunction

    task automatic model_clear();
        exp_db = 0; exp_h = 0; exp_p = 0; run_len = 0; pending = 1'b0;
    endtask

    task automatic model_complete(input int h, input int p);
        if (exp_db != 0) return;
        exp_h = h;
        exp_p = p;
        if (in_tol(h, 50) && in_tol(p, 100)) run_len++;
        else                                 run_len = 0;
        if (run_len == 4) exp_db = 'hA;
    endtask

    // One pad period: high h cycles then low p-h; checks the period that this rise closes.
    task automatic drive_period(input int h, input int p);
        pwm = 1'b1;
        repeat (5) @(negedge HCLK);
        if (pending) begin
            model_complete(pend_h, pend_p);
            check("meas_high", 32'(meas_high), exp_h);
            check("meas_per", 32'(meas_per), exp_p);
        end
        check("db_reg", 32'(db_reg), exp_db);
        pending = (exp_db == 0);
        pend_h  = h;
        pend_p  = p;
        repeat (h - 5) @(negedge HCLK);
        pwm = 1'b0;
        repeat (p - h) @(negedge HCLK);
    endtask

    task automatic good_period();
        drive_period(48 + int'($urandom_range(0, 4)), 98 + int'($urandom_range(0, 4)));
    endtask

    task automatic bad_period();
        if ($urandom_range(0, 1) == 0) drive_period(50, 103 + int'($urandom_range(0, 30)));
        else                           drive_period(30 + int'($urandom_range(0, 17)), 100);
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock.
    task automatic apply_reset();
        #2 HRESETn = 1'b0;
        #1;
        check("rst_db", 32'(db_reg), 0);
        check("rst_mh", 32'(meas_high), 0);
        check("rst_mp", 32'(meas_per), 0);
        pwm = 1'b0;
        repeat (4) @(negedge HCLK);
        HRESETn = 1'b1;
        model_clear();
        repeat (2) @(negedge HCLK);
    endtask

    initial begin
        HRESETn = 1'b0;
        pwm     = 1'bx;
        model_clear();
        repeat (3) @(negedge HCLK);
        check("init_db", 32'(db_reg), 0);
        check("init_mh", 32'(meas_high), 0);
        check("init_mp", 32'(meas_per), 0);
        pwm = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (3) @(negedge HCLK);
        check("post_rst_db", 32'(db_reg), 0);

        // Nominal waveform: PASS on the 4th completed period.
        test_id = 1;
        for (int i = 0; i < 5; i++) drive_period(50, 100);
        check("t1_db", 32'(db_reg), 'hA);
        check("t1_high", 32'(meas_high), 50);
        check("t1_per", 32'(meas_per), 100);

        // Within-tolerance edge values, then random in-tolerance periods.
        test_id = 2;
        apply_reset();
        drive_period(49, 101);
        drive_period(49, 101);
        check("t2_tol_high", 32'(meas_high), 49);
        check("t2_tol_per", 32'(meas_per), 101);
        for (int i = 0; i < 3; i++) good_period();
        check("t2_db", 32'(db_reg), 'hA);

        // Out-of-tolerance period gives no verdict; good run afterwards restarts the count.
        test_id = 3;
        apply_reset();
        for (int i = 0; i < 3; i++) drive_period(50, 110);
        check("t3_per", 32'(meas_per), 110);
        check("t3_db_bad", 32'(db_reg), 0);
        for (int i = 0; i < 4; i++) good_period();
        check("t3_db_3good", 32'(db_reg), 0);
        good_period();
        check("t3_db_4good", 32'(db_reg), 'hA);

        // Random mix of good and bad periods, closed by a good run.
        test_id = 7;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 9) < 7) good_period();
            else                          bad_period();
        end
        for (int i = 0; i < 5; i++) good_period();
        check("t7_db", 32'(db_reg), 'hA);

        // Pad stuck high after a rise: FAIL, and it sticks.
        test_id = 4;
        apply_reset();
        pwm = 1'b1;
        repeat (2040) @(negedge HCLK);
        check("t4_db_before", 32'(db_reg), 0);
        repeat (30) @(negedge HCLK);
        check("t4_db_fail", 32'(db_reg), 'hF);
        exp_db = 'hF;
        pwm = 1'b0;
        repeat (20) @(negedge HCLK);
        for (int i = 0; i < 5; i++) good_period();
        check("t4_db_sticky", 32'(db_reg), 'hF);

        // Pad low forever after reset: IDLE never times out.
        test_id = 5;
        apply_reset();
        repeat (10000) @(negedge HCLK);
        check("t5_db", 32'(db_reg), 0);

        // Reset mid-run clears everything; a full good run afterwards passes.
        test_id = 6;
        apply_reset();
        for (int i = 0; i < 3; i++) drive_period(50, 100);
        check("t6_mh_before", 32'(meas_high), 50);
        apply_reset();
        for (int i = 0; i < 5; i++) good_period();
        check("t6_db", 32'(db_reg), 'hA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
